// File: rtl/zap_shifter_pipe.sv
// rtl/zap_shifter_pipe.sv - pipelined barrel shifter with handshake, flush and saturating LSL (optional ZAP_SHIFTER_STICKY_SAT_EN)
module zap_shifter_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 8,
  parameter int STAGES     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_source,
  input  logic [AMT_WIDTH-1:0]  i_amount,
  input  logic                  i_carry,
  input  logic [2:0]            i_shift_type,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_sat
`ifdef ZAP_SHIFTER_STICKY_SAT_EN
  ,
  input  logic                  i_clr_sat,
  output logic                  o_sat_sticky
`endif
);

  localparam int W    = DATA_WIDTH;
  localparam int L    = $clog2(W);
  localparam int BASE = L / STAGES;
  localparam int REM  = L % STAGES;
  localparam logic [AMT_WIDTH-1:0] AMT_W = AMT_WIDTH'(W);

  typedef enum logic [1:0] {K_LEFT, K_RIGHT, K_ROT} kind_e;

  // First barrel level owned by stage s; earlier stages absorb the remainder.
  function automatic int level_lo(input int s);
    return s * BASE + ((s < REM) ? s : REM);
  endfunction

  logic [W-1:0] p_data;
  logic [L-1:0] p_k;
  kind_e        p_kind;
  logic         p_fill, p_carry, p_sat;

  logic [L-1:0] n_lo, idx_l, idx_r;
  logic         n_zero, n_lt_w, n_eq_w, sign;
  logic [W-1:0] sat_mask;
  logic         sat_hit;

  logic [W-1:0] src_data  [STAGES];
  logic [L-1:0] src_k     [STAGES];
  kind_e        src_kind  [STAGES];
  logic         src_fill  [STAGES];
  logic         src_carry [STAGES];
  logic         src_sat   [STAGES];
  logic         src_valid [STAGES];
  logic [W-1:0] data_n    [STAGES];

  logic [W-1:0] data_q  [STAGES];
  logic [L-1:0] k_q     [STAGES];
  kind_e        kind_q  [STAGES];
  logic         fill_q  [STAGES];
  logic         carry_q [STAGES];
  logic         sat_q   [STAGES];
  logic         valid_q [STAGES];

  logic [W-1:0] d;

  assign n_lo     = i_amount[L-1:0];
  assign n_zero   = (i_amount == '0);
  assign n_lt_w   = (i_amount < AMT_W);
  assign n_eq_w   = (i_amount == AMT_W);
  assign sign     = i_source[W-1];
  assign idx_l    = L'(0) - n_lo;
  assign idx_r    = n_lo - L'(1);
  assign sat_mask = ~(({W{1'b1}} >> 1) >> n_lo);
  assign sat_hit  = n_lt_w ? (|((i_source ^ {W{sign}}) & sat_mask)) : (i_source != '0);

  // Decode the operation into a plain shift/rotate plus precomputed carry and saturation.
  always_comb begin
    p_data  = i_source;
    p_k     = '0;
    p_kind  = K_LEFT;
    p_fill  = 1'b0;
    p_carry = i_carry;
    p_sat   = 1'b0;
    case (i_shift_type)
      3'd0: if (!n_zero) begin
        if (n_lt_w) begin
          p_k = n_lo; p_carry = i_source[idx_l];
        end else begin
          p_data = '0; p_carry = n_eq_w ? i_source[0] : 1'b0;
        end
      end
      3'd1: if (!n_zero) begin
        if (n_lt_w) begin
          p_kind = K_RIGHT; p_k = n_lo; p_carry = i_source[idx_r];
        end else begin
          p_data = '0; p_carry = n_eq_w ? sign : 1'b0;
        end
      end
      3'd2: if (!n_zero) begin
        if (n_lt_w) begin
          p_kind = K_RIGHT; p_fill = sign; p_k = n_lo; p_carry = i_source[idx_r];
        end else begin
          p_data = {W{sign}}; p_carry = sign;
        end
      end
      3'd3: if (!n_zero) begin
        if (n_lo == '0) begin
          p_carry = sign;
        end else begin
          p_kind = K_ROT; p_k = n_lo; p_carry = i_source[idx_r];
        end
      end
      3'd4: begin
        p_data = {i_carry, i_source[W-1:1]}; p_carry = i_source[0];
      end
      3'd5: begin
        p_carry = 1'b0;
        if (sat_hit) begin
          p_sat  = 1'b1;
          p_data = sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else if (n_lt_w) begin
          p_k = n_lo;
        end else begin
          p_data = '0;
        end
      end
      default: ;
    endcase
  end

  // Select each stage's input: decoded operand for stage 0, previous register otherwise.
  always_comb begin
    src_data[0]  = p_data;
    src_k[0]     = p_k;
    src_kind[0]  = p_kind;
    src_fill[0]  = p_fill;
    src_carry[0] = p_carry;
    src_sat[0]   = p_sat;
    src_valid[0] = i_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_data[s]  = data_q[s-1];
      src_k[s]     = k_q[s-1];
      src_kind[s]  = kind_q[s-1];
      src_fill[s]  = fill_q[s-1];
      src_carry[s] = carry_q[s-1];
      src_sat[s]   = sat_q[s-1];
      src_valid[s] = valid_q[s-1];
    end
  end

  // Apply the barrel levels owned by each stage.
  always_comb begin
    d = '0;
    for (int s = 0; s < STAGES; s++) begin
      d = src_data[s];
      for (int l = 0; l < L; l++) begin
        if (l >= level_lo(s) && l < level_lo(s + 1) && src_k[s][l]) begin
          case (src_kind[s])
            K_RIGHT: d = (d >> (1 << l)) | (src_fill[s] ? ~({W{1'b1}} >> (1 << l)) : '0);
            K_ROT:   d = (d >> (1 << l)) | (d << (W - (1 << l)));
            default: d = d << (1 << l);
          endcase
        end
      end
      data_n[s] = d;
    end
  end

  assign o_ready  = !o_valid | i_ready;
  assign o_valid  = valid_q[STAGES-1];
  assign o_result = data_q[STAGES-1];
  assign o_carry  = carry_q[STAGES-1];
  assign o_sat    = sat_q[STAGES-1];

  // Pipeline registers: reset clears all, flush kills valids, global stall holds everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        k_q[s]     <= '0;
        kind_q[s]  <= K_LEFT;
        fill_q[s]  <= 1'b0;
        carry_q[s] <= 1'b0;
        sat_q[s]   <= 1'b0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < STAGES; s++) valid_q[s] <= 1'b0;
    end else if (o_ready) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= src_valid[s];
        data_q[s]  <= data_n[s];
        k_q[s]     <= src_k[s];
        kind_q[s]  <= src_kind[s];
        fill_q[s]  <= src_fill[s];
        carry_q[s] <= src_carry[s];
        sat_q[s]   <= src_sat[s];
      end
    end
  end

`ifdef ZAP_SHIFTER_STICKY_SAT_EN
  // Sticky saturation: set on a saturating output handshake, which beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                     o_sat_sticky <= 1'b0;
    else if (o_valid && i_ready && o_sat) o_sat_sticky <= 1'b1;
    else if (i_clr_sat)                 o_sat_sticky <= 1'b0;
  end
`endif

endmodule
